// File: rtl/alu_unit_if.sv
// Operand/result bus bundle between the A/B bus sources, the ALU and the C bus path.
interface alu_unit_if #(
  parameter int WIDTH = 19
);
  logic             start;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] a_bus;
  logic [WIDTH-1:0] b_bus;
  logic [WIDTH-1:0] alu_out;
  logic             z_flag;
  logic             busy;
  logic             done;

  modport master (
    output start, alu_op, a_bus, b_bus,
    input  alu_out, z_flag, busy, done
  );

  modport slave (
    input  start, alu_op, a_bus, b_bus,
    output alu_out, z_flag, busy, done
  );
endinterface

// File: rtl/alu_unit.sv
// Sequential ALU: single-cycle ops register their result at the start edge;
// MUL is an iterative shift-add that keeps the bus busy for WIDTH cycles.
module alu_unit #(
  parameter int WIDTH = 19,
  parameter int SHW   = 5
) (
  input  logic       clk,
  input  logic       rst,
  alu_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_PASSB = 3'b011,
    OP_INC   = 3'b100,
    OP_SHR   = 3'b101,
    OP_SHL   = 3'b110,
    OP_MUL   = 3'b111
  } op_e;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_e;

  state_e           state, state_n;
  logic [WIDTH-1:0] out_q, out_n;
  logic             z_q, z_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic [WIDTH-1:0] a_lat, a_lat_n;
  logic [WIDTH-1:0] b_lat, b_lat_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]    cnt, cnt_n;

  op_e              op;
  logic [SHW-1:0]   sh;
  int unsigned      shamt;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] mul_sum;

  assign op    = op_e'(bus.alu_op);
  assign sh    = bus.b_bus[SHW-1:0];
  assign shamt = 32'(sh);

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:   result = bus.a_bus + bus.b_bus;
      OP_SUB:   result = bus.a_bus - bus.b_bus;
      OP_PASSB: result = bus.b_bus;
      OP_INC:   result = bus.a_bus + WIDTH'(1);
      OP_SHR:   result = (shamt >= 32'(WIDTH)) ? '0 : (bus.a_bus >> sh);
      OP_SHL:   result = (shamt >= 32'(WIDTH)) ? '0 : (bus.a_bus << sh);
      default:  result = '0;
    endcase
  end

  assign mul_sum = acc + (b_lat[0] ? a_lat : '0);

  always_comb begin
    state_n = state;
    out_n   = out_q;
    z_n     = z_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    a_lat_n = a_lat;
    b_lat_n = b_lat;
    acc_n   = acc;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (op == OP_MUL) begin
            a_lat_n = bus.a_bus;
            b_lat_n = bus.b_bus;
            acc_n   = '0;
            cnt_n   = '0;
            busy_n  = 1'b1;
            state_n = MUL_RUN;
          end else begin
            done_n = 1'b1;
            if (op != OP_NOP) begin
              out_n = result;
              z_n   = (result == '0);
            end
          end
        end
      end
      MUL_RUN: begin
        acc_n   = mul_sum;
        a_lat_n = a_lat << 1;
        b_lat_n = b_lat >> 1;
        cnt_n   = cnt + CW'(1);
        // Final step publishes the sum including this edge's partial product.
        if (cnt == CW'(WIDTH - 1)) begin
          out_n   = mul_sum;
          z_n     = (mul_sum == '0);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      out_q  <= '0;
      z_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      a_lat  <= '0;
      b_lat  <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      out_q  <= out_n;
      z_q    <= z_n;
      busy_q <= busy_n;
      done_q <= done_n;
      a_lat  <= a_lat_n;
      b_lat  <= b_lat_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
    end
  end

  assign bus.alu_out = out_q;
  assign bus.z_flag  = z_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
